// File: rtl/nv_or_reduce_pipe.sv
// rtl/nv_or_reduce_pipe.sv - pipelined FANIN-ary OR-reduction across NUM_IN lanes
// with valid/ready flow control and an optional sticky accumulator on the result.
module nv_or_reduce_pipe #(
    parameter int NUM_IN = 8,
    parameter int WIDTH  = 4,
    parameter int FANIN  = 2
) (
    input  logic                    nvdla_core_clk,
    input  logic                    nvdla_core_rst,
    input  logic                    in_pvld,
    output logic                    in_prdy,
    input  logic [NUM_IN*WIDTH-1:0] in_pd,
    input  logic                    sticky_en,
    input  logic                    sticky_clr,
    output logic                    out_pvld,
    input  logic                    out_prdy,
    output logic [WIDTH-1:0]        out_pd,
    output logic                    out_any
);

    function automatic int calc_lat(input int n, input int f);
        int lvl;
        int cnt;
        lvl = 0;
        cnt = n;
        while (cnt > 1) begin
            cnt = (cnt + f - 1) / f;
            lvl++;
        end
        return (lvl < 1) ? 1 : lvl;
    endfunction

    localparam int LAT = calc_lat(NUM_IN, FANIN);
    localparam int VW  = NUM_IN * WIDTH;

    logic [LAT-1:0]   vld_q, vld_d, stg_rdy, stg_load;
    logic [VW-1:0]    part_q [LAT];
    logic [VW-1:0]    part_d [LAT];
    logic [VW-1:0]    tree   [LAT];
    logic [WIDTH-1:0] acc_q, acc_d, acc_eff, res, fold;
    logic             any_q, any_d;

    always_comb begin
        logic          nxt_rdy;
        logic [VW-1:0] src;
        logic          src_vld;
        nxt_rdy  = out_prdy;
        src      = '0;
        src_vld  = 1'b0;
        stg_rdy  = '0;
        stg_load = '0;
        vld_d    = vld_q;
        res      = '0;
        // Ready ripples back from the output so bubbles collapse in one cycle.
        for (int k = LAT - 1; k >= 0; k--) begin
            stg_rdy[k] = !vld_q[k] || nxt_rdy;
            nxt_rdy    = stg_rdy[k];
        end
        acc_eff = sticky_clr ? '0 : acc_q;
        acc_d   = acc_eff;
        any_d   = any_q;
        for (int k = 0; k < LAT; k++) begin
            if (k == 0) begin
                src     = in_pd;
                src_vld = in_pvld;
            end else begin
                src     = part_q[k-1];
                src_vld = vld_q[k-1];
            end
            tree[k] = '0;
            for (int i = 0; i < NUM_IN; i++) begin
                tree[k][(i/FANIN)*WIDTH +: WIDTH] = tree[k][(i/FANIN)*WIDTH +: WIDTH]
                                                  | src[i*WIDTH +: WIDTH];
            end
            stg_load[k] = src_vld && stg_rdy[k];
            if (stg_rdy[k]) begin
                vld_d[k] = src_vld;
            end
            part_d[k] = stg_load[k] ? tree[k] : part_q[k];
        end
        if (stg_load[LAT-1]) begin
            res            = tree[LAT-1][WIDTH-1:0] | (sticky_en ? acc_eff : '0);
            part_d[LAT-1]  = {{(VW-WIDTH){1'b0}}, res};
            acc_d          = sticky_en ? res : acc_eff;
            any_d          = |res;
        end
    end

    // Only lane 0 of the last level is ever non-zero; folding keeps it a plain OR.
    always_comb begin
        fold = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            fold = fold | part_q[LAT-1][i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            vld_q <= '0;
            acc_q <= '0;
            any_q <= 1'b0;
            for (int k = 0; k < LAT; k++) begin
                part_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            acc_q <= acc_d;
            any_q <= any_d;
            for (int k = 0; k < LAT; k++) begin
                part_q[k] <= part_d[k];
            end
        end
    end

    assign in_prdy  = stg_rdy[0];
    assign out_pvld = vld_q[LAT-1];
    assign out_pd   = fold;
    assign out_any  = any_q;

endmodule

// File: tb/tb_nv_or_reduce_pipe.sv
// tb/tb_nv_or_reduce_pipe.sv - randomized scoreboard bench for nv_or_reduce_pipe
// covering three parameter sets, backpressure, sticky mode and reset.
module tb_nv_or_reduce_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        sticky_en, sticky_clr, sw_sticky_en, sw_sticky_clr;
    logic        in_pvld0, in_prdy0, out_pvld0, out_prdy0, out_any0;
    logic [31:0] in_pd0;
    logic [3:0]  out_pd0;
    logic        in_pvld1, in_prdy1, out_pvld1, out_prdy1, out_any1;
    logic [19:0] in_pd1;
    logic [3:0]  out_pd1;
    logic        in_pvld2, in_prdy2, out_pvld2, out_prdy2, out_any2;
    logic [7:0]  in_pd2;
    logic [3:0]  out_pd2;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_pop    = 0;
    logic [3:0]  expq [$];

    always #5 clk = ~clk;

    nv_or_reduce_pipe #(.NUM_IN(8), .WIDTH(4), .FANIN(2)) u_dut0 (
        .nvdla_core_clk(clk), .nvdla_core_rst(rst),
        .in_pvld(in_pvld0), .in_prdy(in_prdy0), .in_pd(in_pd0),
        .sticky_en(sticky_en), .sticky_clr(sticky_clr),
        .out_pvld(out_pvld0), .out_prdy(out_prdy0), .out_pd(out_pd0), .out_any(out_any0));

    nv_or_reduce_pipe #(.NUM_IN(5), .WIDTH(4), .FANIN(3)) u_dut1 (
        .nvdla_core_clk(clk), .nvdla_core_rst(rst),
        .in_pvld(in_pvld1), .in_prdy(in_prdy1), .in_pd(in_pd1),
        .sticky_en(sw_sticky_en), .sticky_clr(sw_sticky_clr),
        .out_pvld(out_pvld1), .out_prdy(out_prdy1), .out_pd(out_pd1), .out_any(out_any1));

    nv_or_reduce_pipe #(.NUM_IN(2), .WIDTH(4), .FANIN(2)) u_dut2 (
        .nvdla_core_clk(clk), .nvdla_core_rst(rst),
        .in_pvld(in_pvld2), .in_prdy(in_prdy2), .in_pd(in_pd2),
        .sticky_en(sw_sticky_en), .sticky_clr(sw_sticky_clr),
        .out_pvld(out_pvld2), .out_prdy(out_prdy2), .out_pd(out_pd2), .out_any(out_any2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] or_lanes(input logic [31:0] v, input int n);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r = r | v[i*4 +: 4];
        return r;
    endfunction

    function automatic logic [31:0] rand_vec();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 8; i++)
            if ($urandom_range(0, 3) == 0) v[i*4 +: 4] = 4'($urandom_range(1, 15));
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc0(input bit v, input logic [31:0] pd, input logic [3:0] e,
                        input bit op, output bit acc);
        logic [3:0] want;
        in_pvld0  = v;
        in_pd0    = pd;
        out_prdy0 = op;
        #1;
        acc = v && in_prdy0;
        if (out_pvld0 && op) begin
            if (expq.size() == 0) begin
                chk("spurious_out", 32'd1, 32'd0);
            end else begin
                want = expq.pop_front();
                chk("out_pd", 32'(out_pd0), 32'(want));
                chk("out_any", 32'(out_any0), 32'(|want));
                n_pop++;
            end
        end
        if (acc) expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drain0();
        bit a;
        for (int i = 0; i < 20 && expq.size() > 0; i++) cyc0(1'b0, '0, '0, 1'b1, a);
        chk("drain_empty", 32'(expq.size()), 32'd0);
    endtask

    task automatic send_sticky(input logic [31:0] pd, input bit clr_at_load, input logic [3:0] e);
        bit a;
        cyc0(1'b1, pd, e, 1'b1, a);
        chk("stk_accept", 32'(a), 32'd1);
        cyc0(1'b0, '0, '0, 1'b1, a);
        sticky_clr = clr_at_load;
        cyc0(1'b0, '0, '0, 1'b1, a);
        sticky_clr = 1'b0;
        cyc0(1'b0, '0, '0, 1'b1, a);
        cyc0(1'b0, '0, '0, 1'b1, a);
        chk("stk_done", 32'(expq.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          a;
        int          sent, pops0, acc_cnt;
        logic [31:0] pd;
        logic [3:0]  held;
        bit          held_ok;
        logic [31:0] vec1 [20];
        logic [31:0] vec2 [20];

        rst = 1'b1;
        sticky_en = 0; sticky_clr = 0; sw_sticky_en = 0; sw_sticky_clr = 0;
        in_pvld0 = 0; in_pd0 = '0; out_prdy0 = 1;
        in_pvld1 = 0; in_pd1 = '0; out_prdy1 = 1;
        in_pvld2 = 0; in_pd2 = '0; out_prdy2 = 1;

        repeat (3) begin
            tick();
            chk("rst_vld", 32'(out_pvld0), 32'd0);
            chk("rst_pd", 32'(out_pd0), 32'd0);
            chk("rst_any", 32'(out_any0), 32'd0);
        end
        rst = 1'b0;
        tick();
        chk("post_rst_vld", 32'(out_pvld0), 32'd0);
        chk("post_rst_pd", 32'(out_pd0), 32'd0);
        chk("post_rst_rdy", 32'(in_prdy0), 32'd1);

        // single transfer: lanes 0x1 and 0x8 -> 0x9 three cycles after acceptance
        in_pvld0 = 1'b1;
        in_pd0   = 32'h0800_0001;
        #1;
        chk("single_rdy", 32'(in_prdy0), 32'd1);
        tick();
        in_pvld0 = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            chk("single_lat", 32'(out_pvld0), (i == 3) ? 32'd1 : 32'd0);
            if (i < 3) tick();
        end
        chk("single_pd", 32'(out_pd0), 32'h9);
        chk("single_any", 32'(out_any0), 32'd1);
        tick();
        chk("single_gone", 32'(out_pvld0), 32'd0);

        // random streaming with random backpressure
        sent  = 0;
        pops0 = n_pop;
        for (int c = 0; c < 3000 && (sent < 200 || expq.size() > 0); c++) begin
            pd = rand_vec();
            cyc0((sent < 200) && ($urandom_range(0, 3) != 0), pd, or_lanes(pd, 8),
                 1'($urandom_range(0, 1)), a);
            if (a) sent++;
        end
        chk("stream_sent", 32'(sent), 32'd200);
        chk("stream_recv", 32'(n_pop - pops0), 32'd200);

        // full throughput with no backpressure
        for (int c = 0; c < 30; c++) begin
            pd = rand_vec();
            cyc0(1'b1, pd, or_lanes(pd, 8), 1'b1, a);
            chk("thru_rdy", 32'(a), 32'd1);
        end
        drain0();

        // full stall: exactly LAT accepted, output held stable
        acc_cnt = 0;
        held_ok = 1'b0;
        held    = '0;
        for (int c = 0; c < 10; c++) begin
            if (out_pvld0) begin
                if (held_ok) chk("stall_hold", 32'(out_pd0), 32'(held));
                held    = out_pd0;
                held_ok = 1'b1;
            end
            pd = rand_vec();
            cyc0(1'b1, pd, or_lanes(pd, 8), 1'b0, a);
            if (a) acc_cnt++;
        end
        chk("stall_accepted", 32'(acc_cnt), 32'd3);
        chk("stall_rdy", 32'(in_prdy0), 32'd0);
        chk("stall_vld", 32'(out_pvld0), 32'd1);
        drain0();

        // sticky accumulate, coincident clear, non-sticky load
        sticky_en = 1'b1;
        send_sticky(32'h0000_1000, 1'b0, 4'h1);
        send_sticky(32'h0020_0000, 1'b0, 4'h3);
        send_sticky(32'h0000_0040, 1'b0, 4'h7);
        send_sticky(32'h8000_0000, 1'b1, 4'h8);
        sticky_en = 1'b0;
        send_sticky(32'h0000_0002, 1'b0, 4'h2);
        // acc=0x5, then a clear on an idle cycle
        sticky_en = 1'b1;
        send_sticky(32'h4000_0001, 1'b1, 4'h5);
        sticky_clr = 1'b1;
        cyc0(1'b0, '0, '0, 1'b1, a);
        sticky_clr = 1'b0;
        cyc0(1'b0, '0, '0, 1'b1, a);
        send_sticky(32'h0002_0000, 1'b0, 4'h2);

        // reset with three transactions in flight
        for (int i = 0; i < 3; i++) begin
            pd = rand_vec() | 32'h0000_0001;
            cyc0(1'b1, pd, '0, 1'b0, a);
            chk("mf_accept", 32'(a), 32'd1);
        end
        rst = 1'b1;
        cyc0(1'b0, '0, '0, 1'b0, a);
        rst = 1'b0;
        expq.delete();
        chk("mf_vld", 32'(out_pvld0), 32'd0);
        chk("mf_pd", 32'(out_pd0), 32'd0);
        chk("mf_any", 32'(out_any0), 32'd0);
        chk("mf_rdy", 32'(in_prdy0), 32'd1);
        repeat (6) cyc0(1'b0, '0, '0, 1'b1, a);
        send_sticky(32'h0000_0400, 1'b0, 4'h4);
        sticky_en = 1'b0;

        // parameter sweep: (5,3) has LAT=2 with a short group, (2,2) has LAT=1
        for (int c = 0; c < 23; c++) begin
            if (c < 20) begin
                vec1[c]  = rand_vec() & 32'h000F_FFFF;
                vec2[c]  = rand_vec() & 32'h0000_00FF;
                in_pvld1 = 1'b1;
                in_pd1   = vec1[c][19:0];
                in_pvld2 = 1'b1;
                in_pd2   = vec2[c][7:0];
            end else begin
                in_pvld1 = 1'b0;
                in_pvld2 = 1'b0;
            end
            if (c < 20) begin
                chk("sw1_rdy", 32'(in_prdy1), 32'd1);
                chk("sw2_rdy", 32'(in_prdy2), 32'd1);
            end
            if (c >= 2 && c < 22) begin
                chk("sw1_vld", 32'(out_pvld1), 32'd1);
                chk("sw1_pd", 32'(out_pd1), 32'(or_lanes(vec1[c-2], 5)));
                chk("sw1_any", 32'(out_any1), 32'(|or_lanes(vec1[c-2], 5)));
            end else begin
                chk("sw1_idle", 32'(out_pvld1), 32'd0);
            end
            if (c >= 1 && c < 21) begin
                chk("sw2_vld", 32'(out_pvld2), 32'd1);
                chk("sw2_pd", 32'(out_pd2), 32'(or_lanes(vec2[c-1], 2)));
                chk("sw2_any", 32'(out_any2), 32'(|or_lanes(vec2[c-1], 2)));
            end else begin
                chk("sw2_idle", 32'(out_pvld2), 32'd0);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nv_or_reduce_pipe.md
Name: nv_or_reduce_pipe

Overview:
- Parametrised, pipelined successor to the 2-input OR cell: a bitwise OR-reduction across NUM_IN input lanes of WIDTH bits each.
- The reduction is built as a FANIN-ary tree with one register per tree level and a valid/ready handshake.
- An optional sticky mode accumulates results across transactions until cleared.
- Sits in the vlibs as a reusable reduction primitive for status/flag aggregation, e.g. error or busy collection across cores.

Parameters:
- NUM_IN, 8, number of input lanes (>=2).
- WIDTH, 4, bits per lane (>=1).
- FANIN, 2, lanes combined per tree node (>=2).
- LAT, derived = ceil(log_FANIN(NUM_IN)), number of pipeline stages; not user-overridable.

Ports:
- nvdla_core_clk  input  1  core clock; all state on rising edge.
- nvdla_core_rst  input  1  synchronous, active-high reset.
- in_pvld  input  1  input valid.
- in_prdy  output  1  input ready.
- in_pd  input  NUM_IN*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH].
- sticky_en  input  1  sticky accumulate mode; sampled when a result enters the final stage.
- sticky_clr  input  1  single-cycle clear of the sticky accumulator.
- out_pvld  output  1  output valid.
- out_prdy  input  1  output ready.
- out_pd  output  WIDTH  reduced (optionally accumulated) result.
- out_any  output  1  |out_pd, registered alongside out_pd.

Behaviour:
- Reset: every stage valid=0; out_pvld=0, out_pd=0, out_any=0; sticky accumulator acc=0.
- Reset mid-operation discards all in-flight data; no output is produced for it.
- Stage k (1..LAT) holds valid v[k] and a partial vector set. Stage 1 ORs groups of FANIN input lanes. Stage k ORs groups of FANIN stage-(k-1) partials. The last group in a level may be short; missing operands are treated as 0.
- Stage LAT holds a single WIDTH vector, which drives out_pd.
- Handshake per stage:
  - ready[LAT] = !v[LAT] | out_prdy.
  - ready[k] = !v[k] | ready[k+1].
  - in_prdy = ready[1].
  - Transfer occurs when valid & ready on the same cycle.
  - Bubbles collapse; full throughput is 1 transaction/cycle.
  - in_prdy has a combinational path from out_prdy.
- Latency: an accepted input appears on out_pd/out_pvld exactly LAT cycles later when no stalls occur.
- Stall: out_pvld=1 & out_prdy=0 holds out_pd/out_any stable. Upstream stages fill, and in_prdy drops only when all stages are valid.
- Data is never dropped or duplicated; order is preserved.
- Sticky mode, evaluated when a result loads into stage LAT:
  - acc_eff = sticky_clr ? 0 : acc.
  - If sticky_en=1: out_pd <= tree_result | acc_eff, and acc <= same value.
  - If sticky_en=0: out_pd <= tree_result, and acc <= acc_eff.
  - sticky_clr with no load the same cycle: acc <= 0; out_pd is unchanged.
  - Simultaneous clr and load: the clear takes effect first, so the loaded value excludes the old acc.
- out_any is updated on the same cycle and from the same value as out_pd.
- Degenerate case NUM_IN <= FANIN gives LAT=1 (single registered stage).
- in_pd is ignored when in_pvld=0. Stage registers hold their values when not loading.

Test Plan:
- Reset then single transfer: NUM_IN=8, WIDTH=4, FANIN=2 (LAT=3); lanes = 0x1,0,0,0,0,0,0x8,0 -> out_pd=0x9 and out_any=1, out_pvld high exactly 3 cycles after acceptance; all outputs 0 during and after reset.
- Streaming with random backpressure: 200 random vectors, out_prdy toggled randomly -> outputs match the reference OR model in order, with no loss or duplication. With out_prdy=1 throughout, in_prdy stays 1 every cycle.
- Full stall: out_prdy=0 for 10 cycles while in_pvld=1 -> exactly LAT transactions are accepted, then in_prdy=0, and out_pd stays stable. Releasing out_prdy drains in order.
- Sticky accumulate: sticky_en=1, inputs reducing to 0x1, 0x2, 0x4 -> out_pd = 0x1, 0x3, 0x7. Then sticky_clr coincident with a load of 0x8 -> 0x8. Then sticky_en=0 with 0x2 -> 0x2.
- Sticky clear without load: acc=0x5, sticky_clr pulse on an idle cycle, next load of 0x2 with sticky_en=1 -> out_pd=0x2.
- Reset mid-flight: 3 transactions in the pipe, assert nvdla_core_rst for 1 cycle -> out_pvld=0 next cycle, nothing from those transactions emerges, and acc=0.
- Parameter sweep: NUM_IN=5, FANIN=3 (LAT=2, short group) and NUM_IN=2, FANIN=2 (LAT=1) -> correct OR results and latency.
